// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexed seven-segment scanner for NUM_DIGITS digits of 4-bit codes.
// Digit slots are SCAN_DIV cycles long. Each slot opens with a GUARD_CYCLES blanking interval
// against ghosting. Display data is double-buffered and only swapped at the frame wrap, so a
// frame never tears. Digits can also be suppressed by leading-zero blanking and per-digit blink.
module seg_scan_n #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned GUARD_CYCLES = 50,
   parameter int unsigned BLINK_DIV    = 250,
   parameter int unsigned HEX_EN       = 1
) (
   input  logic                    clk_50m,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic                    data_load,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [NUM_DIGITS-1:0]   seg_sel,
   output logic [6:0]              seg_led,
   output logic                    frame_done
);

   localparam int unsigned DATA_W = 4 * NUM_DIGITS;
   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] GUARD_END  = SLOT_W'(GUARD_CYCLES);
   localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);
   localparam logic [BLK_W-1:0]  BLINK_LAST = BLK_W'(BLINK_DIV - 1);

   // Scan timing state
   logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [DIG_W-1:0]  digit_idx_q, digit_idx_d;
   logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;

   // Double buffer
   logic [DATA_W-1:0] disp_q, disp_d;
   logic [DATA_W-1:0] pend_q, pend_d;
   logic              pend_vld_q, pend_vld_d;

   // Registered outputs
   logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
   logic [6:0]            seg_led_q, seg_led_d;
   logic                  frame_done_q, frame_done_d;

   logic                  tick;
   logic                  frame_end;
   logic                  in_guard;
   logic                  zero_run;
   logic [NUM_DIGITS-1:0] lz_sup;
   logic [NUM_DIGITS-1:0] hit;
   logic [3:0]            cur_nib;
   logic                  cur_sup;

   // Active-high segment pattern {g,f,e,d,c,b,a} for a 4-bit code
   function automatic logic [6:0] glyph(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'h0:    g = 7'b0111111;
         4'h1:    g = 7'b0000110;
         4'h2:    g = 7'b1011011;
         4'h3:    g = 7'b1001111;
         4'h4:    g = 7'b1100110;
         4'h5:    g = 7'b1101101;
         4'h6:    g = 7'b1111101;
         4'h7:    g = 7'b0000111;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1101111;
         4'hA:    g = 7'b1110111;
         4'hB:    g = 7'b1111100;
         4'hC:    g = 7'b0111001;
         4'hD:    g = 7'b1011110;
         4'hE:    g = 7'b1111001;
         4'hF:    g = 7'b1110001;
         default: g = 7'b0000000;
      endcase
      // Without hex support, codes above 9 light nothing while the digit stays selected
      if ((HEX_EN == 0) && (code > 4'h9)) begin
         g = 7'b0000000;
      end
      return g;
   endfunction

   // Slot end and frame end strobes
   always_comb begin
      tick      = (slot_cnt_q == SLOT_LAST);
      frame_end = tick && (digit_idx_q == DIGIT_LAST);
      in_guard  = (slot_cnt_q < GUARD_END);
   end

   // Slot counter, digit index and blink phase advance
   always_comb begin
      slot_cnt_d    = tick ? '0 : slot_cnt_q + 1'b1;
      digit_idx_d   = digit_idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (tick) begin
         digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0 : digit_idx_q + 1'b1;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Double-buffered load: display only changes at the frame wrap
   always_comb begin
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (frame_end) begin
         // A load on the wrap cycle itself bypasses the pending buffer
         if (data_load) begin
            disp_d = data_in;
         end else if (pend_vld_q) begin
            disp_d = pend_q;
         end
         pend_vld_d = 1'b0;
      end else if (data_load) begin
         pend_d     = data_in;
         pend_vld_d = 1'b1;
      end
   end

   // Leading-zero suppression: digit i is dark if it and every digit above it are zero
   always_comb begin
      zero_run = 1'b1;
      lz_sup   = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         zero_run  = zero_run & (disp_q[4*i +: 4] == 4'h0);
         lz_sup[i] = blank_lz & zero_run & (i != 0);
      end
   end

   // Select the current digit's code and decide whether it is shown
   always_comb begin
      hit     = '0;
      cur_nib = 4'h0;
      cur_sup = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (DIG_W'(i) == digit_idx_q) begin
            hit[i]  = 1'b1;
            cur_nib = disp_q[4*i +: 4];
            cur_sup = lz_sup[i] | (blink_mask[i] & blink_phase_q);
         end
      end
   end

   // Next output values; everything off in the guard interval or when suppressed
   always_comb begin
      seg_sel_d    = '1;
      seg_led_d    = 7'b0000000;
      frame_done_d = frame_end;
      if (!in_guard && !cur_sup) begin
         seg_sel_d = ~hit;
         seg_led_d = glyph(cur_nib);
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         slot_cnt_q    <= '0;
         digit_idx_q   <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         disp_q        <= '0;
         pend_q        <= '0;
         pend_vld_q    <= 1'b0;
         seg_sel_q     <= '1;
         seg_led_q     <= 7'b0000000;
         frame_done_q  <= 1'b0;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         digit_idx_q   <= digit_idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         disp_q        <= disp_d;
         pend_q        <= pend_d;
         pend_vld_q    <= pend_vld_d;
         seg_sel_q     <= seg_sel_d;
         seg_led_q     <= seg_led_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign seg_sel    = seg_sel_q;
   assign seg_led    = seg_led_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_n.sv
// Scoreboard bench for seg_scan_n: stimulus pushes per-cycle expectations keyed by cycle
// number; a monitor pops and compares on each falling edge. A second instance with hex glyphs
// disabled runs on the same inputs.
module tb_seg_scan_n;

   localparam int T0 = 3;          // last posedge with rst held at start
   localparam int T1 = T0 + 376;   // posedge that samples the mid-run reset

   logic        clk_50m = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic        data_load;
   logic        blank_lz;
   logic [3:0]  blink_mask;
   logic [3:0]  seg_sel, seg_sel_h0;
   logic [6:0]  seg_led, seg_led_h0;
   logic        frame_done, frame_done_h0;

   int t = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      int         t;
      logic [3:0] sel;
      logic [6:0] led;
      logic [6:0] led0;
      logic       fd;
      string      nm;
   } exp_t;

   exp_t sb[$];

   always #5 clk_50m = ~clk_50m;

   always @(posedge clk_50m) t <= t + 1;

   seg_scan_n #(
      .NUM_DIGITS(4), .SCAN_DIV(10), .GUARD_CYCLES(2), .BLINK_DIV(4), .HEX_EN(1)
   ) dut (
      .clk_50m(clk_50m), .rst(rst), .data_in(data_in), .data_load(data_load),
      .blank_lz(blank_lz), .blink_mask(blink_mask), .seg_sel(seg_sel), .seg_led(seg_led),
      .frame_done(frame_done)
   );

   seg_scan_n #(
      .NUM_DIGITS(4), .SCAN_DIV(10), .GUARD_CYCLES(2), .BLINK_DIV(4), .HEX_EN(0)
   ) dut_h0 (
      .clk_50m(clk_50m), .rst(rst), .data_in(data_in), .data_load(data_load),
      .blank_lz(blank_lz), .blink_mask(blink_mask), .seg_sel(seg_sel_h0),
      .seg_led(seg_led_h0), .frame_done(frame_done_h0)
   );

   function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex);
      case (c)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return hex ? 7'b1110111 : 7'b0;
         4'hB: return hex ? 7'b1111100 : 7'b0;
         4'hC: return hex ? 7'b0111001 : 7'b0;
         4'hD: return hex ? 7'b1011110 : 7'b0;
         4'hE: return hex ? 7'b1111001 : 7'b0;
         default: return hex ? 7'b1110001 : 7'b0;
      endcase
   endfunction

   task automatic push_exp(input int tt, input logic [3:0] sel, input logic [6:0] led,
                           input logic [6:0] led0, input logic fd, input string nm);
      exp_t e;
      e.t = tt; e.sel = sel; e.led = led; e.led0 = led0; e.fd = fd; e.nm = nm;
      sb.push_back(e);
   endtask

   // Expected outputs for frame f (first len states) after the reset ending at posedge base.
   // off[i] = 1 means digit i is expected dark for the whole frame.
   task automatic exp_frame(input int base, input int f, input logic [15:0] d,
                            input logic [3:0] off, input int len, input string nm);
      for (int k = 0; k < len; k++) begin
         int         dg;
         logic [3:0] nib;
         logic [3:0] sel;
         dg  = k / 10;
         nib = d[dg*4 +: 4];
         sel = 4'hF;
         if ((k % 10) >= 2 && !off[dg]) begin
            sel[dg] = 1'b0;
            push_exp(base + 1 + f*40 + k, sel, glyph(nib, 1'b1), glyph(nib, 1'b0), k == 39, nm);
         end else begin
            push_exp(base + 1 + f*40 + k, 4'hF, 7'b0, 7'b0, k == 39, nm);
         end
      end
   endtask

   // Park on the falling edge where inputs are sampled for state n after reset at base
   task automatic at_state(input int base, input int n);
      while (t < base + n) @(negedge clk_50m);
   endtask

   task automatic load(input int base, input int n, input logic [15:0] d);
      at_state(base, n);
      data_in   = d;
      data_load = 1'b1;
      @(negedge clk_50m);
      data_load = 1'b0;
   endtask

   // Monitor: compare every expected cycle against both instances
   always @(negedge clk_50m) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].t < t) begin
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s t=%0d: expectation never compared", e.nm, e.t);
      end
      if (sb.size() > 0 && sb[0].t == t) begin
         e = sb.pop_front();
         n_tests++;
         if (seg_sel !== e.sel || seg_led !== e.led || frame_done !== e.fd ||
             seg_sel_h0 !== e.sel || seg_led_h0 !== e.led0 || frame_done_h0 !== e.fd) begin
            n_fail++;
            $display("FAIL %s t=%0d: got sel=%b led=%b fd=%b | h0 sel=%b led=%b fd=%b ; want sel=%b led=%b fd=%b | h0 led=%b",
                     e.nm, t, seg_sel, seg_led, frame_done, seg_sel_h0, seg_led_h0,
                     frame_done_h0, e.sel, e.led, e.fd, e.led0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      data_in    = 16'h0;
      data_load  = 1'b0;
      blank_lz   = 1'b0;
      blink_mask = 4'b0;

      // Reset release, display buffer starts at zero, 1234 appears one frame later
      push_exp(T0, 4'hF, 7'b0, 7'b0, 1'b0, "reset");
      exp_frame(T0, 0, 16'h0000, 4'b0000, 40, "s1_initial_zero");
      exp_frame(T0, 1, 16'h1234, 4'b0000, 40, "s1_1234");
      at_state(T0, 0);
      rst = 1'b0;
      load(T0, 5, 16'h1234);

      // Tearing: two loads during frame 1, only the last shows in frame 2
      exp_frame(T0, 2, 16'h9ABC, 4'b0000, 40, "s2_9abc");
      load(T0, 50, 16'h5678);
      load(T0, 70, 16'h9ABC);

      // Load exactly on the frame-boundary tick
      exp_frame(T0, 3, 16'hDE05, 4'b0000, 40, "s3_boundary_de05");
      load(T0, 119, 16'hDE05);

      // Leading-zero blanking
      exp_frame(T0, 4, 16'h0070, 4'b1100, 40, "s4_lz_0070");
      exp_frame(T0, 5, 16'h0000, 4'b1110, 40, "s4_lz_0000");
      load(T0, 130, 16'h0070);
      at_state(T0, 160);
      blank_lz = 1'b1;
      load(T0, 170, 16'h0000);
      load(T0, 210, 16'h4321);

      // Blink on digit 0: phase flips every 4 ticks, i.e. every frame here
      exp_frame(T0, 6, 16'h4321, 4'b0000, 40, "s5_blink_on");
      exp_frame(T0, 7, 16'h4321, 4'b0001, 40, "s5_blink_off");
      exp_frame(T0, 8, 16'h4321, 4'b0000, 40, "s5_blink_on2");
      at_state(T0, 240);
      blank_lz   = 1'b0;
      blink_mask = 4'b0001;

      // Mid-slot reset drops pending 7777; two frames of zeros follow
      exp_frame(T0, 9, 16'h4321, 4'b0000, 15, "s6_pre_reset");
      push_exp(T1, 4'hF, 7'b0, 7'b0, 1'b0, "s6_mid_reset");
      exp_frame(T1, 0, 16'h0000, 4'b0000, 40, "s6_after_reset");
      exp_frame(T1, 1, 16'h0000, 4'b0000, 40, "s6_pending_dropped");
      at_state(T0, 360);
      blink_mask = 4'b0000;
      load(T0, 365, 16'h7777);
      at_state(T0, 375);
      rst = 1'b1;
      @(negedge clk_50m);
      rst = 1'b0;

      at_state(T1, 82);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_n.md
Name: seg_scan_n

Overview:
- Parametrised multiplexed seven-segment scanner for N digits of 4-bit codes.
- Sits between the traffic-light countdown logic and the board display.
- Adds the following over the fixed 2-digit driver:
  - frame-synchronous double-buffered data load (no tearing mid-scan)
  - ghosting guard interval
  - leading-zero blanking
  - per-digit blink
  - optional hex glyphs
  - a frame-done pulse

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clk_50m cycles per digit slot (1 ms at 50 MHz); must be ≥ 2.
- GUARD_CYCLES, 50: cycles at the start of each slot with all digits off; must be < SCAN_DIV.
- BLINK_DIV, 250: number of slot ticks per blink phase toggle.
- HEX_EN, 1: 1 shows codes 10..15 as A,b,C,d,E,F; 0 shows them blank.

Ports:
- clk_50m, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- data_in, input, 4*NUM_DIGITS: digit codes; digit 0 is bits [3:0] (rightmost), MSB digit is the top nibble.
- data_load, input, 1: single-cycle strobe that captures data_in.
- blank_lz, input, 1: enables leading-zero blanking; level, sampled every cycle.
- blink_mask, input, NUM_DIGITS: bit i=1 makes digit i blink; level.
- seg_sel, output, NUM_DIGITS: digit enables, active-low; bit i drives digit i.
- seg_led, output, 7: segments {g,f,e,d,c,b,a}, active-high (1 = lit).
- frame_done, output, 1: one-cycle pulse at every frame wrap.

Behaviour:
- Clock and reset:
  - One clock, clk_50m; all state updates on its rising edge.
  - rst is synchronous, active-high.
- Reset values:
  - seg_sel = all ones; seg_led = 7'b0000000; frame_done = 0.
  - slot_cnt = 0, digit_idx = 0, blink_cnt = 0, blink_phase = 0 (visible).
  - Display buffer = 0, pending buffer = 0, pending flag = 0.
- Slot counter:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick = (slot_cnt == SCAN_DIV-1).
  - On tick, digit_idx advances by 1, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary:
  - Defined as the tick where digit_idx == NUM_DIGITS-1.
  - frame_done is registered high for exactly the next cycle.
- Data loading (double buffer):
  - data_load=1 and not at a frame boundary: pending <= data_in; pending flag set. The last load before the boundary wins.
  - At a frame boundary with data_load=1: display <= data_in directly; pending flag cleared.
  - At a frame boundary with data_load=0 and pending flag set: display <= pending; flag cleared.
  - The display buffer never changes except at a frame boundary.
- Blink:
  - blink_cnt counts ticks 0..BLINK_DIV-1.
  - On its wrap, blink_phase toggles.
  - Digit i is suppressed when blink_mask[i]=1 and blink_phase=1.
- Leading-zero blanking:
  - Digit i (i ≥ 1) is suppressed when blank_lz=1 and display nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked by this rule.
- Output registers (one-cycle latency from slot_cnt/digit_idx):
  - If slot_cnt < GUARD_CYCLES, or the current digit is suppressed: seg_sel = all ones, seg_led = 0.
  - Otherwise: seg_sel has only bit digit_idx low; seg_led = glyph of display[digit_idx].
- Glyphs:
  - 0..9 use the team's standard active-high segment codes (0 = 7'b0111111, 8 = 7'b1111111).
  - With HEX_EN=1: A = 7'b1110111, b = 7'b1111100, C = 7'b0111001, d = 7'b1011110, E = 7'b1111001, F = 7'b1110001.
  - With HEX_EN=0: codes 10..15 give seg_led = 0; seg_sel is still driven.
- NUM_DIGITS=1: every tick is a frame boundary.
- rst asserted mid-slot or mid-frame: all state returns to reset values on the next edge; pending data is discarded.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=10, GUARD_CYCLES=2, BLINK_DIV=4, HEX_EN=1.
1. Reset release, then load data_in=16'h1234 once:
   - seg_sel stays 4'b1111 until the next frame boundary.
   - Next frame shows digits 0..3 as 4,3,2,1 with seg_sel 1110, 1101, 1011, 0111.
   - Each digit is lit for 8 cycles after a 2-cycle all-off guard.
   - frame_done pulses once every 40 cycles.
2. Tearing check:
   - Load 16'h5678 mid-frame, then 16'h9ABC before the boundary.
   - The current frame still shows 1234; the next frame shows C, b, A, 9.
   - 5678 never appears.
3. Load on the boundary cycle:
   - Pulse data_load in the same cycle as the frame-boundary tick.
   - The new value is displayed in the immediately following frame.
4. Leading-zero blanking:
   - blank_lz=1, data=16'h0070: digits 3 and 2 stay off (seg_sel all ones in their slots); digit 1 shows 7, digit 0 shows 0.
   - data=16'h0000: only digit 0 lights, showing 0.
5. Blink:
   - blink_mask=4'b0001: digit 0 is dark for 4 ticks, then lit for 4 ticks, repeating.
   - The other digits are unaffected.
6. Reset and hex disable:
   - Assert rst mid-slot: the next cycle has seg_sel=4'b1111, seg_led=0, frame_done=0, and pending is dropped.
   - With HEX_EN=0, code 4'hE gives seg_led=0 while seg_sel is still driven.
